bus_arbiter_ctrl: RTL and testbench

Two-master arbiter and transfer sequencer sitting in front of the slave data paths (`slave_data_path` / `slave_control` pairs). It:
- round-robin grants the shared HADDR/HWDATA bus to one of two requesters;
- decodes the address into `hsel_1` or `hsel_2`;
- holds the transfer until the selected slave signals ready;
- returns a per-master completion pulse and error flag.

---
 rtl/bus_arbiter_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_bus_arbiter_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_ctrl.sv
// Two-master round-robin bus arbiter with address decode and slave-ready handshake.
// Optional watchdog: define BUS_TIMEOUT_EN to force an error after TIMEOUT cycles without ready.
module bus_arbiter_ctrl #(
    parameter int         ADDR_W      = 16,
    parameter int         DATA_W      = 32,
    parameter logic [3:0] SLV1_REGION = 4'h0,
    parameter logic [3:0] SLV2_REGION = 4'h1,
    parameter int         TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_m1,
    input  logic              req_m2,
    input  logic [ADDR_W-1:0] addr_m1,
    input  logic [ADDR_W-1:0] addr_m2,
    input  logic [DATA_W-1:0] wdata_m1,
    input  logic [DATA_W-1:0] wdata_m2,
    output logic              gnt_m1,
    output logic              gnt_m2,
    output logic              done_m1,
    output logic              done_m2,
    output logic              err_m1,
    output logic              err_m2,
    output logic [ADDR_W-1:0] HADDR,
    output logic [DATA_W-1:0] HWDATA,
    output logic              hsel_1,
    output logic              hsel_2,
    input  logic              sl_rdy_1,
    input  logic              sl_rdy_2,
    input  logic              slrsp_1,
    input  logic              slrsp_2
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;          // 0: favour M1, 1: favour M2
    logic              owner_q, owner_d;      // 0: M1 owns the bus, 1: M2
    logic              sel1_q, sel1_d;
    logic              sel2_q, sel2_d;
    logic              xfer_err_q, xfer_err_d;
    logic              err_m1_q, err_m1_d;
    logic              err_m2_q, err_m2_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;

    logic              any_req;
    logic              win_m2;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [3:0]        win_region;
    logic              dec_s1;
    logic              dec_s2;
    logic              sel_rdy;
    logic              sel_rsp;
    logic              busy;
    logic              timeout_hit;

    // Arbitration: a lone requester always wins; on contention the pointer decides.
    assign any_req    = req_m1 | req_m2;
    assign win_m2     = req_m2 & (~req_m1 | ptr_q);
    assign win_addr   = win_m2 ? addr_m2 : addr_m1;
    assign win_wdata  = win_m2 ? wdata_m2 : wdata_m1;
    assign win_region = win_addr[ADDR_W-1 -: 4];

    // Slave 1 takes priority if both regions are configured identically.
    assign dec_s1 = (win_region == SLV1_REGION);
    assign dec_s2 = ~dec_s1 & (win_region == SLV2_REGION);

    // Only the decoded slave's handshake is observed.
    assign sel_rdy = (sel1_q & sl_rdy_1) | (sel2_q & sl_rdy_2);
    assign sel_rsp = (sel1_q & slrsp_1) | (sel2_q & slrsp_2);
    assign busy    = (state_q == S_ADDR) || (state_q == S_WAIT);

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts cycles spent in ADDR+WAIT; restarts from zero on every transfer.
    always_comb begin
        cnt_d = '0;
        if (busy) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    // Without the watchdog a transfer waits for ready indefinitely; TIMEOUT is unused.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            sel1_q     <= 1'b0;
            sel2_q     <= 1'b0;
            xfer_err_q <= 1'b0;
            err_m1_q   <= 1'b0;
            err_m2_q   <= 1'b0;
            haddr_q    <= '0;
            hwdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            sel1_q     <= sel1_d;
            sel2_q     <= sel2_d;
            xfer_err_q <= xfer_err_d;
            err_m1_q   <= err_m1_d;
            err_m2_q   <= err_m2_d;
            haddr_q    <= haddr_d;
            hwdata_q   <= hwdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        sel1_d     = sel1_q;
        sel2_d     = sel2_q;
        xfer_err_d = xfer_err_q;
        err_m1_d   = err_m1_q;
        err_m2_d   = err_m2_q;
        haddr_d    = haddr_q;
        hwdata_d   = hwdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d  = win_m2;
                    haddr_d  = win_addr;
                    hwdata_d = win_wdata;
                    sel1_d   = dec_s1;
                    sel2_d   = dec_s2;
                    if (dec_s1 || dec_s2) begin
                        xfer_err_d = 1'b0;
                        state_d    = S_ADDR;
                    end else begin
                        xfer_err_d = 1'b1;
                        state_d    = S_DONE;
                    end
                end
            end
            S_ADDR, S_WAIT: begin
                if (sel_rdy) begin
                    xfer_err_d = sel_rsp;
                    state_d    = S_DONE;
                end else if (timeout_hit) begin
                    xfer_err_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                // Latch the reported status so it persists until this master's next done.
                if (owner_q) begin
                    err_m2_d = xfer_err_q;
                end else begin
                    err_m1_d = xfer_err_q;
                end
                ptr_d   = ~owner_q;
                sel1_d  = 1'b0;
                sel2_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        gnt_m1  = 1'b0;
        gnt_m2  = 1'b0;
        done_m1 = 1'b0;
        done_m2 = 1'b0;
        err_m1  = err_m1_q;
        err_m2  = err_m2_q;
        hsel_1  = 1'b0;
        hsel_2  = 1'b0;
        HADDR   = haddr_q;
        HWDATA  = hwdata_q;

        if (state_q != S_IDLE) begin
            gnt_m1 = ~owner_q;
            gnt_m2 = owner_q;
        end

        if (busy) begin
            hsel_1 = sel1_q;
            hsel_2 = sel2_q;
        end

        // The fresh status is visible in the same cycle as the done pulse.
        if (state_q == S_DONE) begin
            if (owner_q) begin
                done_m2 = 1'b1;
                err_m2  = xfer_err_q;
            end else begin
                done_m1 = 1'b1;
                err_m1  = xfer_err_q;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Directed self-checking bench for bus_arbiter_ctrl: single write, wait states, decode miss,
// async reset mid-transfer, round-robin contention and (with BUS_TIMEOUT_EN) the watchdog.
`timescale 1ns/1ps
module tb_bus_arbiter_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_m1, req_m2;
    logic [ADDR_W-1:0] addr_m1, addr_m2;
    logic [DATA_W-1:0] wdata_m1, wdata_m2;
    logic              gnt_m1, gnt_m2;
    logic              done_m1, done_m2;
    logic              err_m1, err_m2;
    logic [ADDR_W-1:0] HADDR;
    logic [DATA_W-1:0] HWDATA;
    logic              hsel_1, hsel_2;
    logic              sl_rdy_1, sl_rdy_2;
    logic              slrsp_1, slrsp_2;

    int n_checks = 0;
    int n_errors = 0;

    bus_arbiter_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .SLV1_REGION(4'h0),
        .SLV2_REGION(4'h1),
        .TIMEOUT    (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_m1  (req_m1),
        .req_m2  (req_m2),
        .addr_m1 (addr_m1),
        .addr_m2 (addr_m2),
        .wdata_m1(wdata_m1),
        .wdata_m2(wdata_m2),
        .gnt_m1  (gnt_m1),
        .gnt_m2  (gnt_m2),
        .done_m1 (done_m1),
        .done_m2 (done_m2),
        .err_m1  (err_m1),
        .err_m2  (err_m2),
        .HADDR   (HADDR),
        .HWDATA  (HWDATA),
        .hsel_1  (hsel_1),
        .hsel_2  (hsel_2),
        .sl_rdy_1(sl_rdy_1),
        .sl_rdy_2(sl_rdy_2),
        .slrsp_1 (slrsp_1),
        .slrsp_2 (slrsp_2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks every output against the all-zero reset image.
    task automatic check_all_zero(input string tag);
        check({tag, ".gnt"},  {62'd0, gnt_m2, gnt_m1}, 64'd0);
        check({tag, ".done"}, {62'd0, done_m2, done_m1}, 64'd0);
        check({tag, ".err"},  {62'd0, err_m2, err_m1}, 64'd0);
        check({tag, ".hsel"}, {62'd0, hsel_2, hsel_1}, 64'd0);
        check({tag, ".haddr"}, 64'(HADDR), 64'd0);
        check({tag, ".hwdata"}, 64'(HWDATA), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        req_m1 = 1'b0; req_m2 = 1'b0;
        addr_m1 = '0; addr_m2 = '0;
        wdata_m1 = '0; wdata_m2 = '0;
        sl_rdy_1 = 1'b0; sl_rdy_2 = 1'b0;
        slrsp_1 = 1'b0; slrsp_2 = 1'b0;

        #1;
        check_all_zero("reset");
        tick(); tick();
        rst = 1'b1;
        tick();
        check("idle_no_req.gnt", {62'd0, gnt_m2, gnt_m1}, 64'd0);

        // Single write to slave 1, ready tied high.
        sl_rdy_1 = 1'b1;
        req_m1 = 1'b1; addr_m1 = 16'h0008; wdata_m1 = 32'd20;
        tick();
        check("wr.addr.gnt",    {62'd0, gnt_m2, gnt_m1}, 64'b01);
        check("wr.addr.hsel",   {62'd0, hsel_2, hsel_1}, 64'b01);
        check("wr.addr.haddr",  64'(HADDR), 64'h0008);
        check("wr.addr.hwdata", 64'(HWDATA), 64'd20);
        check("wr.addr.done",   {62'd0, done_m2, done_m1}, 64'b00);
        tick();
        check("wr.done.done", {62'd0, done_m2, done_m1}, 64'b01);
        check("wr.done.err",  64'(err_m1), 64'd0);
        check("wr.done.hsel", {62'd0, hsel_2, hsel_1}, 64'b00);
        check("wr.done.gnt",  {62'd0, gnt_m2, gnt_m1}, 64'b01);
        $display("txn M1 write addr=%0h data=%0d", HADDR, HWDATA);
        req_m1 = 1'b0;
        tick();
        check("wr.idle.gnt",   {62'd0, gnt_m2, gnt_m1}, 64'b00);
        check("wr.idle.done",  {62'd0, done_m2, done_m1}, 64'b00);
        check("wr.idle.haddr", 64'(HADDR), 64'h0008);

        // M2 to slave 2 with four wait cycles and an error response;
        // slave 1's ready stays high and must be ignored.
        sl_rdy_2 = 1'b0; slrsp_2 = 1'b1;
        req_m2 = 1'b1; addr_m2 = 16'h1010; wdata_m2 = 32'hCAFE_0001;
        tick();
        check("ws.addr.hsel", {62'd0, hsel_2, hsel_1}, 64'b10);
        check("ws.addr.gnt",  {62'd0, gnt_m2, gnt_m1}, 64'b10);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("ws.wait%0d.hsel", i), {62'd0, hsel_2, hsel_1}, 64'b10);
            check($sformatf("ws.wait%0d.done", i), {62'd0, done_m2, done_m1}, 64'b00);
        end
        tick();
        check("ws.wait4.hsel",  {62'd0, hsel_2, hsel_1}, 64'b10);
        check("ws.wait4.haddr", 64'(HADDR), 64'h1010);
        sl_rdy_2 = 1'b1;
        tick();
        check("ws.done.done",   {62'd0, done_m2, done_m1}, 64'b10);
        check("ws.done.err",    {62'd0, err_m2, err_m1}, 64'b10);
        check("ws.done.hsel",   {62'd0, hsel_2, hsel_1}, 64'b00);
        check("ws.done.hwdata", 64'(HWDATA), 64'hCAFE_0001);
        $display("txn M2 write addr=%0h err=%0b", HADDR, err_m2);
        req_m2 = 1'b0; sl_rdy_2 = 1'b0; slrsp_2 = 1'b0;
        tick();
        check("ws.idle.err_held", {62'd0, err_m2, err_m1}, 64'b10);
        check("ws.idle.done",     {62'd0, done_m2, done_m1}, 64'b00);

        // Decode miss: straight to DONE with error, no slave select.
        req_m1 = 1'b1; addr_m1 = 16'h3000; wdata_m1 = 32'd7;
        tick();
        check("miss.done",  {62'd0, done_m2, done_m1}, 64'b01);
        check("miss.err",   {62'd0, err_m2, err_m1}, 64'b11);
        check("miss.hsel",  {62'd0, hsel_2, hsel_1}, 64'b00);
        check("miss.gnt",   {62'd0, gnt_m2, gnt_m1}, 64'b01);
        check("miss.haddr", 64'(HADDR), 64'h3000);
        $display("txn M1 decode miss addr=%0h err=%0b", HADDR, err_m1);
        req_m1 = 1'b0;
        tick();
        check("miss.idle.gnt", {62'd0, gnt_m2, gnt_m1}, 64'b00);

        // Asynchronous reset while M1 sits in WAIT.
        sl_rdy_1 = 1'b0;
        req_m1 = 1'b1; addr_m1 = 16'h0100;
        tick();
        tick();
        check("rstmid.wait.hsel", {62'd0, hsel_2, hsel_1}, 64'b01);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rstmid");
        $display("txn M1 aborted by reset");

        // Contention from reset: M1, M2, M1, M2 with one IDLE cycle between.
        req_m1 = 1'b1; req_m2 = 1'b1;
        addr_m1 = 16'h0004; addr_m2 = 16'h1004;
        sl_rdy_1 = 1'b1; sl_rdy_2 = 1'b1;
        tick();
        rst = 1'b1;
        for (int t = 0; t < 4; t++) begin
            logic [1:0] exp_oh;
            exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            check($sformatf("rr%0d.addr.gnt", t), {62'd0, gnt_m2, gnt_m1}, 64'(exp_oh));
            check($sformatf("rr%0d.addr.haddr", t), 64'(HADDR),
                  (t % 2 == 0) ? 64'h0004 : 64'h1004);
            tick();
            check($sformatf("rr%0d.done", t), {62'd0, done_m2, done_m1}, 64'(exp_oh));
            $display("txn rr%0d winner=M%0d", t, (t % 2 == 0) ? 1 : 2);
            if (t == 3) begin
                req_m1 = 1'b0; req_m2 = 1'b0;
            end
            tick();
            check($sformatf("rr%0d.idle.gnt", t), {62'd0, gnt_m2, gnt_m1}, 64'b00);
        end

        // Pointer now favours M1, yet a lone M2 request must still win.
        req_m2 = 1'b1;
        tick();
        check("lone_m2.gnt", {62'd0, gnt_m2, gnt_m1}, 64'b10);
        tick();
        check("lone_m2.done", {62'd0, done_m2, done_m1}, 64'b10);
        $display("txn lone M2 winner granted");
        req_m2 = 1'b0;
        tick();

`ifdef BUS_TIMEOUT_EN
        // Watchdog: slave 1 never ready; DONE with error after 16 busy cycles.
        sl_rdy_1 = 1'b0;
        req_m1 = 1'b1; addr_m1 = 16'h0010;
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        check("to.pre.hsel", {62'd0, hsel_2, hsel_1}, 64'b01);
        check("to.pre.done", {62'd0, done_m2, done_m1}, 64'b00);
        tick();
        check("to.done", {62'd0, done_m2, done_m1}, 64'b01);
        check("to.err",  64'(err_m1), 64'd1);
        check("to.hsel", {62'd0, hsel_2, hsel_1}, 64'b00);
        $display("txn M1 timeout err=%0b", err_m1);
        req_m1 = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
